crack_result_display: RTL and testbench

// Control/readout stage downstream of the dual-cracker (doublecrack). Waits for the cracker's rdy,

---
 rtl/crack_result_display.sv | 164 ++++++++++++++++
 tb/tb_crack_result_display.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/crack_result_display.sv
// rtl/crack_result_display.sv - start/readout controller for the dual cracker
// Fires one crack_en per search, shows progress snapshots while running, then latches the result.
module crack_result_display #(
    parameter int REFRESH_CYCLES = 5_000_000,
    parameter bit SHOW_PROGRESS  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        restart,
    input  logic        crack_rdy,
    input  logic        key_valid,
    input  logic [23:0] key,
    input  logic [23:0] probe_key,
    output logic        crack_en,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [2:0]  LEDR
);

    localparam int              CW       = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [6:0]      SEG_BLANK = 7'b1111111;
    localparam logic [6:0]      SEG_DASH  = 7'b0111111;

    typedef enum logic [2:0] {
        S_WAIT_RDY,
        S_START,
        S_GUARD,
        S_RUN,
        S_FOUND,
        S_FAIL
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_refresh_cnt;
    logic [23:0]      r_snapshot;
    logic [23:0]      r_result;
    logic             r_crack_en;
    logic [5:0][6:0]  r_hex;
    logic [2:0]       r_led;
    logic [5:0][6:0]  w_hex;
    logic [2:0]       w_led;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    function automatic logic [5:0][6:0] seg_word(input logic [23:0] v);
        for (int i = 0; i < 6; i++) begin
            seg_word[i] = seg7(v[i*4 +: 4]);
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT_RDY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT_RDY: if (crack_rdy) w_next = S_START;
            S_START:    w_next = S_GUARD;
            // The cracker only drops rdy a cycle after en, so rdy is not trusted here.
            S_GUARD:    w_next = S_RUN;
            S_RUN:      if (crack_rdy) w_next = key_valid ? S_FOUND : S_FAIL;
            S_FOUND,
            S_FAIL:     if (restart) w_next = S_WAIT_RDY;
            default:    w_next = S_WAIT_RDY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh_cnt <= '0;
            r_snapshot    <= '0;
            r_result      <= '0;
        end else begin
            case (r_state)
                S_START: begin
                    r_snapshot    <= probe_key;
                    r_refresh_cnt <= '0;
                end
                S_RUN: begin
                    r_refresh_cnt <= (r_refresh_cnt == CNT_LAST) ? '0 : r_refresh_cnt + 1'b1;
                    // A finishing search wins over a coincident snapshot refresh.
                    if (crack_rdy) begin
                        if (key_valid) r_result <= key;
                    end else if (r_refresh_cnt == CNT_LAST) begin
                        r_snapshot <= probe_key;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_hex = {6{SEG_BLANK}};
        w_led = 3'b000;
        case (r_state)
            S_RUN: begin
                w_led = 3'b001;
                if (SHOW_PROGRESS) w_hex = seg_word(r_snapshot);
            end
            S_FOUND: begin
                w_led = 3'b010;
                w_hex = seg_word(r_result);
            end
            S_FAIL: begin
                w_led = 3'b100;
                w_hex = {6{SEG_DASH}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crack_en <= 1'b0;
            r_hex      <= {6{SEG_BLANK}};
            r_led      <= 3'b000;
        end else begin
            r_crack_en <= (w_next == S_START);
            r_hex      <= w_hex;
            r_led      <= w_led;
        end
    end

    assign crack_en = r_crack_en;
    assign HEX0     = r_hex[0];
    assign HEX1     = r_hex[1];
    assign HEX2     = r_hex[2];
    assign HEX3     = r_hex[3];
    assign HEX4     = r_hex[4];
    assign HEX5     = r_hex[5];
    assign LEDR     = r_led;

endmodule

// File: tb/tb_crack_result_display.sv
// tb/tb_crack_result_display.sv - directed bench for crack_result_display
// Instance a shows progress, instance b has SHOW_PROGRESS=0; both share stimulus.
module tb_crack_result_display;

    logic        clk = 1'b0;
    logic        rst_n, restart, crack_rdy, key_valid;
    logic [23:0] key, probe_key;
    logic        a_en, b_en;
    logic [6:0]  a_h0, a_h1, a_h2, a_h3, a_h4, a_h5;
    logic [6:0]  b_h0, b_h1, b_h2, b_h3, b_h4, b_h5;
    logic [2:0]  a_led, b_led;
    logic [41:0] a_hex, b_hex;

    localparam logic [41:0] ALL_BLANK = {6{7'b1111111}};
    localparam logic [41:0] ALL_DASH  = {6{7'b0111111}};

    assign a_hex = {a_h5, a_h4, a_h3, a_h2, a_h1, a_h0};
    assign b_hex = {b_h5, b_h4, b_h3, b_h2, b_h1, b_h0};

    always #5 clk = ~clk;

    crack_result_display #(.REFRESH_CYCLES(4), .SHOW_PROGRESS(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .restart(restart), .crack_rdy(crack_rdy),
        .key_valid(key_valid), .key(key), .probe_key(probe_key), .crack_en(a_en),
        .HEX0(a_h0), .HEX1(a_h1), .HEX2(a_h2), .HEX3(a_h3), .HEX4(a_h4), .HEX5(a_h5),
        .LEDR(a_led)
    );

    crack_result_display #(.REFRESH_CYCLES(4), .SHOW_PROGRESS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .restart(restart), .crack_rdy(crack_rdy),
        .key_valid(key_valid), .key(key), .probe_key(probe_key), .crack_en(b_en),
        .HEX0(b_h0), .HEX1(b_h1), .HEX2(b_h2), .HEX3(b_h3), .HEX4(b_h4), .HEX5(b_h5),
        .LEDR(b_led)
    );

    typedef struct {
        bit          kv;
        logic [23:0] k;
        bit          guard;
        bit          mid_restart;
        logic [41:0] exp_hex;
        logic [2:0]  exp_led;
    } vec_t;

    vec_t vt[5];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        probe_key = probe_key + 24'd1;
    endtask

    task automatic wait_en(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_en) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 64'(seen), 64'd1);
    endtask

    function automatic logic [6:0] enc(input int n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    function automatic int dec_hex(input logic [41:0] h);
        int v;
        int d;
        v = 0;
        for (int i = 5; i >= 0; i--) begin
            d = -1;
            for (int n = 0; n < 16; n++) begin
                if (h[i*7 +: 7] == enc(n)) d = n;
            end
            if (d < 0) return -1;
            v = v * 16 + d;
        end
        return v;
    endfunction

    initial begin
        int en_cnt;
        int b_bad;
        int changes;
        int bad_delta;
        int bad_dec;
        int vals [17];

        vt[0] = '{1'b1, 24'h000018, 1'b0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h00}, 3'b010};
        vt[1] = '{1'b0, 24'h987654, 1'b0, 1'b0, ALL_DASH, 3'b100};
        vt[2] = '{1'b1, 24'hABCDEF, 1'b1, 1'b0, {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 3'b010};
        vt[3] = '{1'b1, 24'h123456, 1'b0, 1'b1, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 3'b010};
        vt[4] = '{1'b1, 24'h09F0C7, 1'b1, 1'b1, {7'h40, 7'h10, 7'h0E, 7'h40, 7'h46, 7'h78}, 3'b010};

        rst_n = 1'b0; restart = 1'b0; crack_rdy = 1'b0; key_valid = 1'b0;
        key = '0; probe_key = '0;
        tick(); tick();
        check("reset_en", 64'(a_en), 64'd0);
        check("reset_hex", 64'(a_hex), 64'(ALL_BLANK));
        check("reset_led", 64'(a_led), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            crack_rdy = 1'b1; key_valid = 1'b0; key = '0;
            wait_en($sformatf("v%0d_en_seen", v));
            tick();
            check($sformatf("v%0d_en_one_cycle", v), 64'(a_en), 64'd0);
            if (vt[v].guard) tick();
            crack_rdy = 1'b0;
            en_cnt = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (a_en) en_cnt++;
                if (vt[v].mid_restart) restart = (i == 5);
            end
            restart = 1'b0;
            check($sformatf("v%0d_no_en_in_run", v), 64'(en_cnt), 64'd0);
            check($sformatf("v%0d_run_busy", v), 64'(a_led), 64'd1);

            key = vt[v].k; key_valid = vt[v].kv; crack_rdy = 1'b1;
            tick();
            key = 24'h555555; key_valid = 1'b0;
            tick(); tick();
            check($sformatf("v%0d_result_hex", v), 64'(a_hex), 64'(vt[v].exp_hex));
            check($sformatf("v%0d_result_led", v), 64'(a_led), 64'(vt[v].exp_led));

            key = ~vt[v].k; key_valid = ~vt[v].kv;
            tick(); tick(); tick();
            check($sformatf("v%0d_hold_hex", v), 64'(a_hex), 64'(vt[v].exp_hex));
            check($sformatf("v%0d_hold_led", v), 64'(a_led), 64'(vt[v].exp_led));

            crack_rdy = 1'b0; restart = 1'b1;
            tick();
            restart = 1'b0;
            tick();
            check($sformatf("v%0d_restart_hex", v), 64'(a_hex), 64'(ALL_BLANK));
            check($sformatf("v%0d_restart_led", v), 64'(a_led), 64'd0);
        end

        // Progress snapshots: probe_key advances by one per cycle, refresh period is 4.
        crack_rdy = 1'b1; key_valid = 1'b0;
        wait_en("prog_en_seen");
        tick();
        crack_rdy = 1'b0;
        b_bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i >= 10 && i < 27) vals[i-10] = dec_hex(a_hex);
            if (i >= 2 && b_hex !== ALL_BLANK) b_bad++;
        end
        changes = 0; bad_delta = 0; bad_dec = 0;
        for (int j = 0; j < 17; j++) if (vals[j] < 0) bad_dec++;
        for (int j = 1; j < 17; j++) begin
            if (vals[j] != vals[j-1]) begin
                changes++;
                if (vals[j] - vals[j-1] != 4) bad_delta++;
            end
        end
        check("prog_digits_valid", 64'(bad_dec), 64'd0);
        check("prog_change_count", 64'(changes), 64'd4);
        check("prog_step", 64'(bad_delta), 64'd0);
        check("prog_led_a", 64'(a_led), 64'd1);
        check("noprog_led_b", 64'(b_led), 64'd1);
        check("noprog_blank_b", 64'(b_bad), 64'd0);
        crack_rdy = 1'b1;
        tick(); tick();
        check("prog_fail_hex", 64'(a_hex), 64'(ALL_DASH));
        crack_rdy = 1'b0; restart = 1'b1;
        tick();
        restart = 1'b0;
        tick();

        // Reset in the middle of a run, then a single fresh start.
        crack_rdy = 1'b1;
        wait_en("rst_en_seen");
        tick();
        crack_rdy = 1'b0;
        repeat (8) tick();
        check("rst_pre_busy", 64'(a_led), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_en", 64'(a_en), 64'd0);
        check("rst_async_hex", 64'(a_hex), 64'(ALL_BLANK));
        check("rst_async_led", 64'(a_led), 64'd0);
        repeat (3) tick();
        crack_rdy = 1'b1;
        rst_n = 1'b1;
        wait_en("rst_rearm_en");
        en_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (a_en) en_cnt++;
        end
        check("rst_single_en", 64'(en_cnt), 64'd0);
        check("rst_end_fail_led", 64'(a_led), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
